fios_result_collector: RTL and testbench
========================================

# fios_result_collector

Receiving end of the DSP cascade result path. Accepts the 34-bit partial-product words the last DSP stage emits, one limb weight per cycle. Resolves the pending inter-limb carries into canonical 17-bit limbs and buffers them in a FIFO. The finished operand is presented on a valid/ready stream, so a downstream consumer can absorb the DSP's fixed-rate output at its own pace.

## Interface
- `LIMB_COUNT`, 8: limbs per operand; ≥ 2.
- `FIFO_DEPTH`, 16: limb buffer entries; power of two, ≥ `LIMB_COUNT`.
- `clock_i` in 1: single clock; all state updates on rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `P_valid_i` in 1: `P_i` carries a result word this cycle. Cannot be stalled.
- `P_i` in 34: DSP result word, limb weight 2^(17·k).
- `limb_o` out 17: resolved limb at FIFO head.
- `limb_valid_o` out 1: `limb_o` valid.
- `limb_ready_i` in 1: consumer accepts `limb_o`.
- `limb_last_o` out 1: head limb is limb `LIMB_COUNT-1` of its operand.
- `level_o` out clog2(`FIFO_DEPTH`)+1: FIFO occupancy.
- `overflow_o` out 1: sticky; a word was dropped because the FIFO was full.
- `carry_o` out 18: final carry of the operand. Valid when `limb_valid_o & limb_last_o`. Present only with `FIOS_RESULT_CARRY_OUT_EN`.

## Operation
- Input index counter `idx` runs 0..`LIMB_COUNT`-1. It advances on each accepted `P_valid_i` and wraps to 0 after the last limb.
- Carry register `carry` is 18 bits. The running sum is `sum = P_i + (idx==0 ? 0 : carry)`, 35 bits, zero-extended.
- On an accepted word:
  - Push `sum[16:0]` as the limb, with last flag = (`idx == LIMB_COUNT-1`).
  - Update `carry <= sum[34:17]`.
  - The carry is discarded at the operand boundary.
- With `FIOS_RESULT_CARRY_OUT_EN`, the last-limb FIFO entry also stores `sum[34:17]`. Entry width is 17+1+18 with the macro, 17+1 without.
- Pop: the head is removed when `limb_valid_o & limb_ready_i`.
- Full, no pop, `P_valid_i`:
  - The word is dropped and `overflow_o` is set to 1 until reset.
  - `idx` and `carry` still advance, so operand framing is kept; the data is corrupt and flagged.
- Full with a pop in the same cycle: the push is accepted and the level is unchanged.
- Empty with a push: no bypass; the limb becomes visible the next cycle.
- `limb_ready_i` while empty: ignored.
- `P_valid_i` low: `idx` and `carry` hold. Gaps inside an operand are legal.
- Read and write pointers wrap modulo `FIFO_DEPTH`. Full/empty are distinguished by the extra MSB of the pointers.

## Timing
- Reset values (asynchronous, while `reset_i` is high):
  - `idx=0`, `carry=0`, pointers 0.
  - `limb_valid_o=0`, `limb_last_o=0`, `limb_o=0`, `level_o=0`, `overflow_o=0`, `carry_o=0`.
- Reset mid-operand discards the partial operand and all buffered limbs. The first word after release is treated as limb 0.
- Latency: a word accepted at edge t appears at `limb_o` after edge t. This holds when the FIFO is empty or its older entries have been popped.
- `level_o` updates on the same edge as the push or pop. A simultaneous push and pop gives net 0.
- Throughput: one limb per cycle in, one per cycle out.

## Configuration
- `FIOS_RESULT_CARRY_OUT_EN` defined:
  - The `carry_o` port exists.
  - The final carry is stored with the last limb and presented with it.
  - Non-last entries present `carry_o=0`.
- Undefined:
  - No `carry_o` port and no carry storage.
  - The final carry is silently discarded.
  - All other behaviour is identical.

## Test plan
- `LIMB_COUNT=2`, words 0x20005 then 0x1FFFF, ready high → limbs 0x00005 (last=0), then 0x00000 (last=1). With the macro, `carry_o=1`.
- Words 0x3_FFFF_FFFF ×2 → limb0 0x1FFFF, carry 0x1FFFF. Sum1 = 0x4_0001_FFFE → limb1 0x1FFFE, `carry_o` 0x20000 (macro). Checks 35-bit sum and 18-bit carry.
- `limb_ready_i` held low, 17 words into `FIFO_DEPTH=16` → `level_o=16`, `overflow_o=1` on the 17th. The first 16 limbs drain intact.
- Full FIFO, push and pop in the same cycle → `level_o` stays 16, `overflow_o` stays 0, order preserved.
- Two back-to-back operands, second limb0 = 0x5 after a first operand ending with carry 0x3 → second limb0 = 0x00005 (carry reset at boundary).
- `reset_i` pulsed after limb 1 of 8 → outputs at reset values immediately. The next word is limb0 with carry 0.

Source files
------------

// File: rtl/fios_result_collector.sv
// DSP cascade result collector: folds inter-limb carries into 17-bit limbs and streams them out of a FIFO.
// Optional macro FIOS_RESULT_CARRY_OUT_EN adds carry_o, the final carry stored with each last limb.
module fios_result_collector #(
  parameter int LIMB_COUNT = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          P_valid_i,
  input  logic [33:0]                   P_i,
  output logic [16:0]                   limb_o,
  output logic                          limb_valid_o,
  input  logic                          limb_ready_i,
  output logic                          limb_last_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o
`ifdef FIOS_RESULT_CARRY_OUT_EN
  ,
  output logic [17:0]                   carry_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(LIMB_COUNT);
`ifdef FIOS_RESULT_CARRY_OUT_EN
  localparam int EW = 17 + 1 + 18;
`else
  localparam int EW = 17 + 1;
`endif

  logic [IW-1:0] idx_reg;
  logic [17:0]   carry_reg;
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          overflow_reg;
  logic [EW-1:0] mem [FIFO_DEPTH];

  logic [34:0]   sum;
  logic          is_last;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic [EW-1:0] entry_in;
  logic [EW-1:0] head;

  // Carry from the previous limb only applies inside an operand.
  assign is_last = (idx_reg == IW'(LIMB_COUNT - 1));
  assign sum     = {1'b0, P_i} + ((idx_reg == '0) ? 35'd0 : {17'd0, carry_reg});

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop   = !empty && limb_ready_i;
  assign push  = P_valid_i && (!full || pop);

`ifdef FIOS_RESULT_CARRY_OUT_EN
  assign entry_in = {(is_last ? sum[34:17] : 18'd0), is_last, sum[16:0]};
`else
  assign entry_in = {is_last, sum[16:0]};
`endif

  // Framing state advances on every presented word, even a dropped one.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      idx_reg   <= '0;
      carry_reg <= '0;
    end else if (P_valid_i) begin
      idx_reg   <= is_last ? '0 : idx_reg + 1'b1;
      carry_reg <= sum[34:17];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (P_valid_i && !push) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= entry_in;
  end

  // Outputs are forced to zero while empty so reset and idle present clean values.
  assign head         = mem[rd_ptr_reg[AW-1:0]];
  assign limb_valid_o = !empty;
  assign limb_o       = empty ? 17'd0 : head[16:0];
  assign limb_last_o  = empty ? 1'b0 : head[17];
  assign level_o      = wr_ptr_reg - rd_ptr_reg;
  assign overflow_o   = overflow_reg;
`ifdef FIOS_RESULT_CARRY_OUT_EN
  assign carry_o      = empty ? 18'd0 : head[35:18];
`endif

endmodule

// File: tb/tb_fios_result_collector.sv
// Directed bench for fios_result_collector with LIMB_COUNT=2, FIFO_DEPTH=16.
module tb_fios_result_collector;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        P_valid_i = 1'b0;
  logic [33:0] P_i = '0;
  logic        limb_ready_i = 1'b0;
  logic [16:0] limb_o;
  logic        limb_valid_o;
  logic        limb_last_o;
  logic [4:0]  level_o;
  logic        overflow_o;
  logic [17:0] carry_o;

  int n_checks = 0;
  int n_fail = 0;

  fios_result_collector #(.LIMB_COUNT(2), .FIFO_DEPTH(16)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .P_valid_i    (P_valid_i),
    .P_i          (P_i),
    .limb_o       (limb_o),
    .limb_valid_o (limb_valid_o),
    .limb_ready_i (limb_ready_i),
    .limb_last_o  (limb_last_o),
    .level_o      (level_o),
    .overflow_o   (overflow_o)
`ifdef FIOS_RESULT_CARRY_OUT_EN
    ,
    .carry_o      (carry_o)
`endif
  );

`ifndef FIOS_RESULT_CARRY_OUT_EN
  assign carry_o = '0;
`endif

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic        v;
    logic [33:0] p;
    logic        rdy;
    logic        ev;
    logic [16:0] el;
    logic        elast;
    logic [4:0]  elvl;
    logic        eovf;
    logic [17:0] ec;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [33:0] p, input logic r);
    P_valid_i    = v;
    P_i          = p;
    limb_ready_i = r;
    @(posedge clock_i);
    #1;
  endtask

  task automatic do_reset();
    P_valid_i    = 1'b0;
    limb_ready_i = 1'b0;
    reset_i      = 1'b1;
    #3;
    reset_i      = 1'b0;
    @(posedge clock_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              v   p               rdy ev  limb       last lvl  ovf  carry
    tbl[0]  = '{1'b1, 34'h0_0002_0005, 1'b1, 1'b1, 17'h00005, 1'b0, 5'd1, 1'b0, 18'h00000};
    tbl[1]  = '{1'b1, 34'h0_0001_FFFF, 1'b1, 1'b1, 17'h00000, 1'b1, 5'd1, 1'b0, 18'h00001};
    tbl[2]  = '{1'b1, 34'h3_FFFF_FFFF, 1'b1, 1'b1, 17'h1FFFF, 1'b0, 5'd1, 1'b0, 18'h00000};
    tbl[3]  = '{1'b1, 34'h3_FFFF_FFFF, 1'b1, 1'b1, 17'h1FFFE, 1'b1, 5'd1, 1'b0, 18'h20000};
    tbl[4]  = '{1'b1, 34'h0_0000_0003, 1'b1, 1'b1, 17'h00003, 1'b0, 5'd1, 1'b0, 18'h00000};
    tbl[5]  = '{1'b1, 34'h0_0006_0000, 1'b1, 1'b1, 17'h00000, 1'b1, 5'd1, 1'b0, 18'h00003};
    tbl[6]  = '{1'b1, 34'h0_0000_0005, 1'b1, 1'b1, 17'h00005, 1'b0, 5'd1, 1'b0, 18'h00000};
    tbl[7]  = '{1'b1, 34'h0_0000_0007, 1'b1, 1'b1, 17'h00007, 1'b1, 5'd1, 1'b0, 18'h00000};
    tbl[8]  = '{1'b0, 34'h0,           1'b1, 1'b0, 17'h00000, 1'b0, 5'd0, 1'b0, 18'h00000};
    tbl[9]  = '{1'b0, 34'h0,           1'b1, 1'b0, 17'h00000, 1'b0, 5'd0, 1'b0, 18'h00000};
    tbl[10] = '{1'b1, 34'h0_0002_0001, 1'b0, 1'b1, 17'h00001, 1'b0, 5'd1, 1'b0, 18'h00000};
    tbl[11] = '{1'b0, 34'h0,           1'b0, 1'b1, 17'h00001, 1'b0, 5'd1, 1'b0, 18'h00000};
    tbl[12] = '{1'b1, 34'h0_0000_0010, 1'b0, 1'b1, 17'h00001, 1'b0, 5'd2, 1'b0, 18'h00000};
    tbl[13] = '{1'b0, 34'h0,           1'b1, 1'b1, 17'h00011, 1'b1, 5'd1, 1'b0, 18'h00000};
    tbl[14] = '{1'b0, 34'h0,           1'b1, 1'b0, 17'h00000, 1'b0, 5'd0, 1'b0, 18'h00000};

    // Reset state while reset is held.
    #3;
    check("reset valid", 36'(limb_valid_o), 36'd0);
    check("reset limb", 36'(limb_o), 36'd0);
    check("reset last", 36'(limb_last_o), 36'd0);
    check("reset level", 36'(level_o), 36'd0);
    check("reset ovf", 36'(overflow_o), 36'd0);
    check("reset carry", 36'(carry_o), 36'd0);
    reset_i = 1'b0;
    @(posedge clock_i);
    #1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].p, tbl[i].rdy);
      check($sformatf("v%0d valid", i), 36'(limb_valid_o), 36'(tbl[i].ev));
      check($sformatf("v%0d limb", i), 36'(limb_o), 36'(tbl[i].el));
      check($sformatf("v%0d last", i), 36'(limb_last_o), 36'(tbl[i].elast));
      check($sformatf("v%0d level", i), 36'(level_o), 36'(tbl[i].elvl));
      check($sformatf("v%0d ovf", i), 36'(overflow_o), 36'(tbl[i].eovf));
`ifdef FIOS_RESULT_CARRY_OUT_EN
      check($sformatf("v%0d carry", i), 36'(carry_o), 36'(tbl[i].ec));
`endif
    end

    // Overflow: 17 words into a 16-entry FIFO with the consumer stalled.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      step(1'b1, 34'(k + 1), 1'b0);
      check($sformatf("ovf fill%0d level", k), 36'(level_o), 36'((k < 16) ? k + 1 : 16));
      check($sformatf("ovf fill%0d flag", k), 36'(overflow_o), 36'((k < 16) ? 0 : 1));
    end
    for (int k = 0; k < 16; k++) begin
      check($sformatf("ovf drain%0d limb", k), 36'(limb_o), 36'(k + 1));
      check($sformatf("ovf drain%0d last", k), 36'(limb_last_o), 36'(k % 2));
      step(1'b0, 34'd0, 1'b1);
    end
    check("ovf drained level", 36'(level_o), 36'd0);
    check("ovf sticky", 36'(overflow_o), 36'd1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    check("post-reset ovf clear", 36'(overflow_o), 36'd0);
    for (int k = 0; k < 16; k++) step(1'b1, 34'(256 + k), 1'b0);
    check("full level", 36'(level_o), 36'd16);
    step(1'b1, 34'h200, 1'b1);
    check("full pushpop level", 36'(level_o), 36'd16);
    check("full pushpop ovf", 36'(overflow_o), 36'd0);
    for (int k = 1; k < 17; k++) begin
      check($sformatf("full drain%0d limb", k), 36'(limb_o), 36'((k < 16) ? 256 + k : 512));
      check($sformatf("full drain%0d last", k), 36'(limb_last_o), 36'((k < 16) ? k % 2 : 0));
      step(1'b0, 34'd0, 1'b1);
    end
    check("full drained level", 36'(level_o), 36'd0);

    // Asynchronous reset in the middle of an operand.
    do_reset();
    step(1'b1, 34'h6_0001, 1'b0);
    check("midop limb0", 36'(limb_o), 36'h1);
    P_valid_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    check("async valid", 36'(limb_valid_o), 36'd0);
    check("async limb", 36'(limb_o), 36'd0);
    check("async level", 36'(level_o), 36'd0);
    #1;
    reset_i = 1'b0;
    @(posedge clock_i);
    #1;
    step(1'b1, 34'h5, 1'b0);
    check("after reset limb", 36'(limb_o), 36'h5);
    check("after reset last", 36'(limb_last_o), 36'd0);
    step(1'b1, 34'h9, 1'b0);
    check("after reset level", 36'(level_o), 36'd2);
    step(1'b0, 34'd0, 1'b1);
    check("after reset limb1", 36'(limb_o), 36'h9);
    check("after reset last1", 36'(limb_last_o), 36'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
